// File: rtl/seq_divider_pkg.sv
// seq_divider_pkg: shared width default and FSM state encoding for the sequential divider.
package seq_divider_pkg;

    localparam int DIV_WIDTH = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/seq_divider_div_step.sv
// div_step: one restoring-division step; shift in the dividend MSB, trial-subtract, keep or restore.
module div_step #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic             msb_i,
    input  logic [WIDTH-1:0] dvs_i,
    output logic [WIDTH:0]   rem_o,
    output logic             q_o
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] diff;

    // One extra bit so the sign of the trial subtraction is explicit
    always_comb begin
        shifted = {rem_i, msb_i};
        diff    = shifted - {2'b00, dvs_i};
        q_o     = ~diff[WIDTH+1];
        rem_o   = q_o ? diff[WIDTH:0] : shifted[WIDTH:0];
    end

endmodule

// File: rtl/seq_divider.sv
// seq_divider: radix-2 restoring unsigned divider, one quotient bit per cycle.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] dvd_q, dvd_d, dvs_q, dvs_d;
    logic [WIDTH:0]   rem_q, rem_d, rem_step;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             dz_q, dz_d, q_bit;
    logic             busy_q, busy_d, done_q, done_d, div_by_zero_q, div_by_zero_d;
    logic [WIDTH-1:0] quotient_q, quotient_d, remainder_q, remainder_d;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i (rem_q),
        .msb_i (dvd_q[WIDTH-1]),
        .dvs_i (dvs_q),
        .rem_o (rem_step),
        .q_o   (q_bit)
    );

    // dvd_q shifts out dividend bits and shifts in quotient bits, ending as the quotient
    always_comb begin
        state_d       = state_q;
        dvd_d         = dvd_q;
        dvs_d         = dvs_q;
        rem_d         = rem_q;
        cnt_d         = cnt_q;
        dz_d          = dz_q;
        done_d        = 1'b0;
        quotient_d    = quotient_q;
        remainder_d   = remainder_q;
        div_by_zero_d = div_by_zero_q;
        case (state_q)
            IDLE: begin
                if (start && b == '0) begin
                    state_d = DONE;
                    dvd_d   = '1;
                    dvs_d   = '0;
                    rem_d   = {1'b0, a};
                    cnt_d   = '0;
                    dz_d    = 1'b1;
                end else if (start) begin
                    state_d = RUN;
                    dvd_d   = a;
                    dvs_d   = b;
                    rem_d   = '0;
                    cnt_d   = CW'(WIDTH);
                    dz_d    = 1'b0;
                end
            end
            RUN: begin
                dvd_d   = {dvd_q[WIDTH-2:0], q_bit};
                rem_d   = rem_step;
                cnt_d   = cnt_q - CW'(1);
                state_d = (cnt_q == CW'(1)) ? DONE : RUN;
            end
            DONE: begin
                state_d       = IDLE;
                done_d        = 1'b1;
                quotient_d    = dvd_q;
                remainder_d   = rem_q[WIDTH-1:0];
                div_by_zero_d = dz_q;
            end
            default: state_d = IDLE;
        endcase
        busy_d = state_d != IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            dvd_q         <= '0;
            dvs_q         <= '0;
            rem_q         <= '0;
            cnt_q         <= '0;
            dz_q          <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            div_by_zero_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            dvd_q         <= dvd_d;
            dvs_q         <= dvs_d;
            rem_q         <= rem_d;
            cnt_q         <= cnt_d;
            dz_q          <= dz_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            quotient_q    <= quotient_d;
            remainder_q   <= remainder_d;
            div_by_zero_q <= div_by_zero_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = div_by_zero_q;

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 64: operand, quotient and remainder width in bits.
REQ-002 SHALL have port clk, input, 1: single clock, rising-edge.
REQ-003 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port start, input, 1: request a division; sampled only in IDLE.
REQ-005 SHALL have port a, input, WIDTH: dividend, unsigned.
REQ-006 SHALL have port b, input, WIDTH: divisor, unsigned.
REQ-007 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-008 SHALL have port done, output, 1: one-cycle pulse; quotient and remainder are valid.
REQ-009 SHALL have port quotient, output, WIDTH: a / b.
REQ-010 SHALL have port remainder, output, WIDTH: a mod b.
REQ-011 SHALL have port div_by_zero, output, 1: the last completed operation had b == 0.

Function
REQ-012 SHALL implement a radix-2 restoring divider with three states, IDLE, RUN and DONE, producing one quotient bit per cycle in RUN.
REQ-013 SHALL, in IDLE with start=1 and b!=0, latch a and b, clear the partial remainder, load the bit counter with WIDTH, and go to RUN.
REQ-014 SHALL, in IDLE with start=1 and b==0, go directly to DONE with quotient = all ones, remainder = a and div_by_zero = 1.
REQ-015 SHALL, each RUN cycle, shift the dividend MSB into the partial remainder (WIDTH+1 bits wide, so there is no overflow), subtract the divisor, and do the following:
  - on a non-negative result, keep the difference and shift in quotient bit 1;
  - otherwise, restore the partial remainder and shift in quotient bit 0.
REQ-016 SHALL decrement the counter every RUN cycle and go to DONE after exactly WIDTH RUN cycles.
REQ-017 SHALL, in DONE, assert done for exactly one cycle, update quotient, remainder and div_by_zero, then return to IDLE.
REQ-018 SHALL give a latency from the edge that samples start to the cycle with done=1 of WIDTH+1 cycles when b!=0, and 1 cycle when b==0.
REQ-019 SHALL ignore start in RUN and DONE; operands held in the internal registers SHALL NOT change.
REQ-020 SHALL hold quotient, remainder and div_by_zero stable between done pulses; a and b may change freely after the start cycle.
REQ-021 SHALL accept a new start in the IDLE cycle immediately after DONE, giving back-to-back throughput of one result per WIDTH+2 cycles.
REQ-022 SHALL, when a < b, produce quotient = 0 and remainder = a, with the normal WIDTH+1 latency.

Reset
REQ-023 SHALL, with rst=1 at a clock edge, enter IDLE and clear busy, done, quotient, remainder, div_by_zero, the counter and all internal registers to 0.
REQ-024 SHALL, on reset during RUN or DONE, abort the operation with no done pulse; reset has priority over start.

Structure
REQ-025 SHALL put the WIDTH default and the state enumeration (IDLE, RUN, DONE) in the shared processor package.
REQ-026 SHALL place the combinational shift/subtract/select step in one sub-module, div_step (inputs: partial remainder, dividend MSB, divisor; outputs: next partial remainder, quotient bit).
REQ-027 SHALL keep the FSM, counter and registers in seq_divider; there SHALL be no other sub-modules.

Verification
REQ-028 SHALL cover: a=100, b=7, start pulse -> done exactly 65 cycles later, quotient=14, remainder=2, div_by_zero=0.
REQ-029 SHALL cover: a=0x1234, b=0 -> done 1 cycle later, quotient=0xFFFF_FFFF_FFFF_FFFF, remainder=0x1234, div_by_zero=1.
REQ-030 SHALL cover: a=0xFFFF_FFFF_FFFF_FFFF with b=1 -> quotient=a, remainder=0; and with b=a -> quotient=1, remainder=0.
REQ-031 SHALL cover: a=5, b=9 -> quotient=0, remainder=5; a second start with a=9, b=5 in the IDLE cycle after done -> quotient=1, remainder=4.
REQ-032 SHALL cover: start with a=1000, b=10; a start with a=7, b=0 asserted 10 cycles later -> ignored; result quotient=100, remainder=0, div_by_zero=0.
REQ-033 SHALL cover: rst=1 in RUN cycle 30 -> busy=0 next cycle, no done pulse, all outputs 0; a new start then completes normally.
